// File: rtl/mem_arbiter_if.sv
// One memory-port bus: request operands from the master, completion and read data back.
// The arbiter takes a slave modport per master and drives the memory through a master modport.
interface mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            req;
   logic            wen;
   logic [2:0]      mode;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [XLEN-1:0] rdata;
   logic            ready;
   logic            err;

   modport master (output req, wen, mode, addr, wdata, input rdata, ready, err);
   modport slave  (input req, wen, mode, addr, wdata, output rdata, ready, err);
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the single memory port: IDLE -> BUSY -> DONE,
// registered outputs, per-transaction timeout reported through mN_err.
module mem_arbiter #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  m0,
   mem_arbiter_if.slave  m1,
   mem_arbiter_if.master slv,
   output logic [1:0]    gnt
);
   localparam int CW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                 state_q, state_d;
   logic                   last_q, last_d;
   logic [1:0]             gnt_q, gnt_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   sreq_q, sreq_d;
   logic                   swen_q, swen_d;
   logic [2:0]             smode_q, smode_d;
   logic [XLEN-1:0]        saddr_q, saddr_d;
   logic [XLEN-1:0]        swdata_q, swdata_d;
   logic [1:0][XLEN-1:0]   rdata_q, rdata_d;
   logic [1:0]             ready_q, ready_d;
   logic [1:0]             err_q, err_d;
   logic [1:0]             req;
   logic                   win;
   logic                   own;
   logic                   unused_slv_err;

   assign req            = {m1.req, m0.req};
   assign own            = gnt_q[1];
   assign unused_slv_err = slv.err;

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      gnt_d    = gnt_q;
      cnt_d    = cnt_q;
      sreq_d   = sreq_q;
      swen_d   = swen_q;
      smode_d  = smode_q;
      saddr_d  = saddr_q;
      swdata_d = swdata_q;
      rdata_d  = rdata_q;
      ready_d  = '0;
      err_d    = '0;
      win      = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               // on a tie the master that did not win last time goes first
               win      = (req == 2'b11) ? ~last_q : req[1];
               state_d  = BUSY;
               last_d   = win;
               gnt_d    = win ? 2'b10 : 2'b01;
               cnt_d    = '0;
               sreq_d   = 1'b1;
               swen_d   = win ? m1.wen   : m0.wen;
               smode_d  = win ? m1.mode  : m0.mode;
               saddr_d  = win ? m1.addr  : m0.addr;
               swdata_d = win ? m1.wdata : m0.wdata;
            end
         end
         BUSY: begin
            if (slv.ready) begin
               state_d      = DONE;
               sreq_d       = 1'b0;
               swen_d       = 1'b0;
               ready_d[own] = 1'b1;
               rdata_d[own] = slv.rdata;
            end else if (TIMEOUT != 0 && cnt_q == TMAX) begin
               state_d      = DONE;
               sreq_d       = 1'b0;
               swen_d       = 1'b0;
               ready_d[own] = 1'b1;
               err_d[own]   = 1'b1;
               rdata_d[own] = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            // requests are deliberately not looked at here so a held req is not re-granted
            state_d = IDLE;
            gnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         gnt_q    <= '0;
         cnt_q    <= '0;
         sreq_q   <= 1'b0;
         swen_q   <= 1'b0;
         smode_q  <= '0;
         saddr_q  <= '0;
         swdata_q <= '0;
         rdata_q  <= '0;
         ready_q  <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         gnt_q    <= gnt_d;
         cnt_q    <= cnt_d;
         sreq_q   <= sreq_d;
         swen_q   <= swen_d;
         smode_q  <= smode_d;
         saddr_q  <= saddr_d;
         swdata_q <= swdata_d;
         rdata_q  <= rdata_d;
         ready_q  <= ready_d;
         err_q    <= err_d;
      end
   end

   assign gnt       = gnt_q;
   assign slv.req   = sreq_q;
   assign slv.wen   = swen_q;
   assign slv.mode  = smode_q;
   assign slv.addr  = saddr_q;
   assign slv.wdata = swdata_q;
   assign m0.rdata  = rdata_q[0];
   assign m0.ready  = ready_q[0];
   assign m0.err    = err_q[0];
   assign m1.rdata  = rdata_q[1];
   assign m1.ready  = ready_q[1];
   assign m1.err    = err_q[1];
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master, one-slave arbiter for the single memory port. Master 0 is the core's load/store/fetch port and master 1 is a secondary bus master (loader/DMA/debug). The block serializes their transactions onto one slave port with round-robin priority, registered outputs and a per-transaction timeout. It sits between the masters and the memory/peripheral interconnect, and keeps the slave port's wen/mode/addr/wdata/rdata/ready signal set.

## Interface
Parameters:
- XLEN, 32, data and address width.
- TIMEOUT, 255, maximum cycles in BUSY waiting for slave ready; 0 disables the timeout.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous active-high reset.
- mN_req  input  1  (N=0,1) request; held high with operands stable until mN_ready.
- mN_wen  input  1  1 = write, 0 = read.
- mN_mode  input  3  access size/sign code, passed through unchanged.
- mN_addr  input  XLEN  byte address.
- mN_wdata  input  XLEN  write data.
- mN_rdata  output  XLEN  read data, valid only while mN_ready=1.
- mN_ready  output  1  one-cycle completion pulse.
- mN_err  output  1  qualifies mN_ready: transaction timed out.
- slv_req  output  1  transaction valid to slave.
- slv_wen  output  1  write enable; 0 whenever slv_req=0.
- slv_mode  output  3  latched mode.
- slv_addr  output  XLEN  latched address.
- slv_wdata  output  XLEN  latched write data.
- slv_rdata  input  XLEN  slave read data, sampled with slv_ready.
- slv_ready  input  1  slave completion; ignored outside BUSY.
- gnt  output  2  one-hot current owner (bit N = master N), 00 when idle.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, neither request: stay in IDLE.
- IDLE, exactly one request: grant that master.
- IDLE, both requests: grant the master not in `last`. `last` resets to 1, so master 0 wins the first tie.
- On grant, latch the winner's wen/mode/addr/wdata into the slv_* registers, set gnt, update `last` to the winner, clear the timeout counter, and go to BUSY.
- BUSY:
  - slv_req=1 and slv_* are stable.
  - If slv_ready=1, capture slv_rdata into the winner's rdata register (writes capture too; the value is don't-care) and go to DONE with err=0.
  - Otherwise the counter increments. When TIMEOUT≠0 and the counter reaches TIMEOUT-1 without slv_ready, go to DONE with err=1 and rdata=0.
- DONE:
  - mN_ready=1 for the granted master only; mN_err as decided.
  - slv_req=0, slv_wen=0.
  - Requests are not sampled in DONE. This prevents re-granting a master whose req is still high during its ready cycle.
  - Next state is IDLE with gnt=00.
- Masters drop or re-present req in the cycle after mN_ready. A req still high when IDLE is reached is a new transaction.
- Changes to the non-granted master's inputs have no effect on the slave port.
- Counter width is ceil(log2(TIMEOUT+1)), minimum 1. It saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values: slv_req/slv_wen 0, slv_mode 0, slv_addr/slv_wdata 0, mN_rdata 0, mN_ready/mN_err 0, gnt 00, state IDLE, last 1, counter 0.
- Reset mid-transaction drops slv_req asynchronously and discards the transaction. No ready pulse is issued.
- Latency, with req first sampled in IDLE at edge E:
  - slv_req rises after E.
  - slv_ready sampled at edge E+L (L≥1).
  - mN_ready is high during the cycle after E+L.
  - Back in IDLE one cycle later.
- Minimum 3 cycles per transaction with a zero-wait slave (L=1). Peak throughput is 1 transaction every 3 cycles.
- Timeout: with no slv_ready, mN_ready/mN_err rise TIMEOUT cycles after slv_req rose.
- slv_ready held high across DONE/IDLE is ignored. It is acted on only in BUSY.

## Test plan
- Reset, then idle: all outputs equal reset values. Assert rst in BUSY → slv_req=0 immediately and no mN_ready afterwards.
- m0 read addr=0x100, slave returns 0xDEADBEEF with L=1 → slv_req high 1 cycle, m0_ready 1 cycle later with m0_rdata=0xDEADBEEF and err=0. m1 never sees ready.
- m0 and m1 request together, both holding req continuously for 4 transactions → grant order 0,1,0,1. Each master's slv_addr and wen match its own inputs.
- m1 write addr=0x2000 wdata=0x12345678 mode=3'b010, slave waits L=5 → slv_* stable for all 5 BUSY cycles. m1_ready follows with err=0. m0 req raised mid-transaction is granted only after DONE.
- TIMEOUT=8, slave never ready → m0_ready and m0_err pulse 8 cycles after slv_req rose, m0_rdata=0. The arbiter returns to IDLE and serves m1's pending request next.
- Master keeps req high through its ready cycle with no competitor → no duplicate grant in DONE. The new grant happens in the following IDLE cycle, giving exactly 3-cycle spacing with L=1.
